// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request per instruction and holds the returned word for decode/execute.
// Optional build macro IFU_ALIGN_CHECK_EN: a misaligned dnpc at the consumer handshake stops fetch with a fault.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] dnpc,
  input  logic        halt,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              req_valid_q, req_valid_d;
  logic              inst_valid_q, inst_valid_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic              misalign_c;
  logic [XLEN-1:0]   npc_c;

`ifdef IFU_ALIGN_CHECK_EN
  // Keep the raw target so a misaligned jump is visible when debugging the fault.
  assign misalign_c = (dnpc[1:0] != 2'b00);
  assign npc_c      = dnpc;
`else
  assign misalign_c = 1'b0;
  assign npc_c      = dnpc & ~XLEN'(3);
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            fault_d = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          pc_d = npc_c;
          if (misalign_c) begin
            fault_d = 1'b1;
            state_d = S_STOP;
          end else if (halt) begin
            halted_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase

    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
    inst_d       = INST_NOP;
    if (state_d == S_HOLD) inst_d = (state_q == S_HOLD) ? inst_q : imem_rsp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= INST_NOP;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected requests/instructions are queued by the stimulus and popped by a negedge monitor.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } inst_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        imem_rsp_err   = 1'b0;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc, dnpc;
  logic        halt, halted, fault;

  logic        dnpc_plus4;
  logic [31:0] dnpc_fixed;
  int          rsp_delay;
  logic        rsp_err_mode;
  int          inject_n;

  int          vectors = 0;
  int          miscompares = 0;
  int          req_cnt = 0;
  int          inst_cnt = 0;
  int          cyc = 0;
  int          last_req_cyc = -1;
  logic        chk_period;
  logic [31:0] exp_addr_q[$];
  inst_t       exp_inst_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dnpc = dnpc_plus4 ? pc + 32'd4 : dnpc_fixed;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .dnpc(dnpc), .halt(halt), .halted(halted), .fault(fault)
  );

  // addi x1, x0, addr[11:0]: a distinct word per fetch address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[11:0], 20'h00093};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inst(input int target, input string name);
    int b = 0;
    while (inst_cnt < target && b < 200) begin
      tick();
      b++;
    end
    check(name, 32'(inst_cnt >= target), 32'd1);
  endtask

  task automatic wait_req(input int target, input string name);
    int b = 0;
    while (req_cnt < target && b < 200) begin
      tick();
      b++;
    end
    check(name, 32'(req_cnt >= target), 32'd1);
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic with_inst);
    exp_addr_q.push_back(a);
    if (with_inst) exp_inst_q.push_back('{inst: mem_word(a), pc: a});
  endtask

  // Monitor: pops the scoreboard on every handshake the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        req_cnt++;
        if (exp_addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got addr %h, want no request", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (chk_period && last_req_cyc >= 0) check("req_period", 32'(cyc - last_req_cyc), 32'd3);
        last_req_cyc = cyc;
      end
      if (inst_valid && inst_ready) begin
        inst_t e;
        inst_cnt++;
        if (exp_inst_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_inst: got inst %h pc %h, want none", inst, pc);
        end else begin
          e = exp_inst_q.pop_front();
          check("inst_word", inst, e.inst);
          check("inst_pc", pc, e.pc);
        end
      end
      if (!inst_valid) check("inst_nop_idle", inst, NOP);
    end
  end

  // Instruction memory: answers each accepted request after rsp_delay extra cycles.
  initial begin
    logic        hs, pend;
    logic [31:0] hs_addr, paddr;
    int          cnt, inject_done;
    pend = 1'b0; paddr = 32'h0; cnt = 0; inject_done = 0;
    forever begin
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready && rst_n;
      hs_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          pend  = 1'b1;
          cnt   = rsp_delay;
          paddr = hs_addr;
        end
        if (pend) begin
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
            imem_rsp_err   = rsp_err_mode;
            pend           = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (inject_n != inject_done) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hDEAD_BEEF;
          inject_done    = inject_n;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; halt = 1'b0;
    dnpc_plus4 = 1'b1; dnpc_fixed = 32'h0; rsp_delay = 0; rsp_err_mode = 1'b0;
    inject_n = 0; chk_period = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, NOP);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // Zero-wait streaming, one instruction per 3 cycles
    for (int i = 0; i < 4; i++) push_fetch(RST_PC + 32'(4 * i), 1'b1);
    chk_period = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, RST_PC);
    wait_inst(4, "stream_timeout");
    imem_req_ready = 1'b0;
    chk_period = 1'b0;

    // Request back-pressure, then a slow response
    inst_ready = 1'b0;
    dnpc_plus4 = 1'b0;
    dnpc_fixed = 32'h8000_0100;
    rsp_delay  = 5;
    push_fetch(32'h8000_0010, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_addr, 32'h8000_0010);
    end
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("one_req_accepted", 32'(req_cnt), 32'd5);
    repeat (6) begin
      @(negedge clk);
      check("slow_rsp_no_valid", 32'(inst_valid), 32'd0);
    end
    @(negedge clk);
    check("slow_rsp_valid", 32'(inst_valid), 32'd1);

    // Consumer back-pressure in HOLD, then redirect to 8000_0100
    repeat (3) begin
      check("hold_inst", inst, mem_word(32'h8000_0010));
      check("hold_pc", pc, 32'h8000_0010);
      @(negedge clk);
    end
    push_fetch(32'h8000_0100, 1'b1);
    rsp_delay = 0;
    tick();
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    wait_inst(5, "redirect_timeout");

    // Halt on the next handshake
    halt = 1'b1;
    dnpc_plus4 = 1'b1;
    wait_inst(6, "halt_timeout");
    @(negedge clk);
    check("halted_set", 32'(halted), 32'd1);
    check("halt_no_fault", 32'(fault), 32'd0);
    check("halt_req_valid", 32'(imem_req_valid), 32'd0);
    check("halt_pc", pc, 32'h8000_0104);
    inject_n++;
    repeat (3) tick();
    @(negedge clk);
    check("stop_inst_valid", 32'(inst_valid), 32'd0);
    check("stop_inst", inst, NOP);
    check("stop_pc", pc, 32'h8000_0104);
    check("stop_req_cnt", 32'(req_cnt), 32'd6);

    // Reset pulse restarts fetch; the response carries an error
    halt = 1'b0;
    rsp_err_mode = 1'b1;
    push_fetch(RST_PC, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_pulse_pc", pc, RST_PC);
    check("rst_pulse_halted", 32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_req(7, "restart_timeout");
    repeat (3) tick();
    @(negedge clk);
    check("err_fault", 32'(fault), 32'd1);
    check("err_halted", 32'(halted), 32'd0);
    check("err_req_valid", 32'(imem_req_valid), 32'd0);
    check("err_inst_valid", 32'(inst_valid), 32'd0);
    check("err_req_cnt", 32'(req_cnt), 32'd7);
    check("err_inst_cnt", 32'(inst_cnt), 32'd6);

    // Asynchronous reset while waiting for a response
    tick();
    rst_n = 1'b0;
    rsp_err_mode = 1'b0;
    rsp_delay = 3;
    push_fetch(RST_PC, 1'b0);
    tick();
    rst_n = 1'b1;
    wait_req(8, "wait_state_timeout");
    rst_n = 1'b0;
    #1;
    check("async_req_valid", 32'(imem_req_valid), 32'd0);
    check("async_inst_valid", 32'(inst_valid), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_inst", inst, NOP);
    check("async_pc", pc, RST_PC);
    repeat (2) tick();

    // Misaligned dnpc
    rsp_delay = 0;
    dnpc_plus4 = 1'b0;
    dnpc_fixed = 32'h8000_0102;
    push_fetch(RST_PC, 1'b1);
`ifdef IFU_ALIGN_CHECK_EN
    tick();
    rst_n = 1'b1;
    wait_inst(7, "align_timeout");
    @(negedge clk);
    check("align_fault", 32'(fault), 32'd1);
    check("align_halted", 32'(halted), 32'd0);
    check("align_pc", pc, 32'h8000_0102);
    repeat (3) tick();
    check("align_req_cnt", 32'(req_cnt), 32'd9);
`else
    push_fetch(32'h8000_0100, 1'b1);
    tick();
    rst_n = 1'b1;
    wait_inst(7, "align_timeout");
    halt = 1'b1;
    wait_inst(8, "align_halt_timeout");
    @(negedge clk);
    check("align_halted", 32'(halted), 32'd1);
    check("align_no_fault", 32'(fault), 32'd0);
    check("align_pc", pc, 32'h8000_0100);
    repeat (3) tick();
    check("align_req_cnt", 32'(req_cnt), 32'd10);
`endif

    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("inst_q_empty", 32'(exp_inst_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit directly upstream of the single-cycle decode/execute stage. It owns the architectural PC and issues one request per instruction to instruction memory over a valid/ready request channel with a valid-only response. It holds the returned instruction and its PC for decode/execute. When the consumer accepts the instruction, the PC advances to the consumer's `dnpc`. Fetch stops permanently on a halt (ebreak) or a fault.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `INST_NOP`, 32'h0000_0013, value driven on `inst` while no instruction is held.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_rsp_valid`  in  1  response data valid, single-cycle pulse.
- `imem_rsp_data`  in  32  fetched instruction word.
- `imem_rsp_err`  in  1  access error, qualified by `imem_rsp_valid`.
- `inst_valid`  out  1  `inst`/`pc` hold a fetched instruction.
- `inst_ready`  in  1  decode/execute consumes the instruction this cycle.
- `inst`  out  32  held instruction.
- `pc`  out  32  PC of held/requested instruction.
- `dnpc`  in  32  next PC from decode/execute, sampled when `inst_valid && inst_ready`.
- `halt`  in  1  current instruction is ebreak, sampled on the same handshake.
- `halted`  out  1  fetch stopped by halt, sticky.
- `fault`  out  1  fetch stopped by error, sticky.

## Operation
- Five states: IDLE, REQ, WAIT, HOLD, STOP.
- IDLE: entered on reset. Moves to REQ on the next edge.
- REQ: `imem_req_valid`=1.
  - `imem_req_ready`=1: go to WAIT.
  - Otherwise stay in REQ. `imem_addr` stays stable.
- WAIT: waits for `imem_rsp_valid`.
  - Valid with no error: latch `imem_rsp_data` into `inst` and go to HOLD.
  - Valid with `imem_rsp_err`=1: set `fault` and go to STOP.
- HOLD: `inst_valid`=1.
  - On `inst_ready`=1: `pc` <= `dnpc`.
  - If `halt`=1 at that handshake: set `halted`, go to STOP. `pc` still takes `dnpc`.
  - Otherwise go to REQ.
- STOP: absorbing state. Outputs stay frozen until reset: `imem_req_valid`=0, `inst_valid`=0, `inst`=`INST_NOP`.
- `inst` is `INST_NOP` in every state except HOLD.
- `imem_rsp_valid` outside WAIT is ignored. It does not change state or `inst`.
- `pc` changes only on the HOLD handshake or on reset. 32-bit arithmetic, no wrap detection: `dnpc`=0 is legal.

## Timing
- Reset values: `pc`=`RESET_PC`, `inst`=`INST_NOP`, `inst_valid`=0, `imem_req_valid`=0, `halted`=0, `fault`=0, state IDLE.
- Reset asserted mid-transaction (REQ/WAIT/HOLD) returns to IDLE immediately and drops all valids. A late response after reset release lands in IDLE/REQ and is ignored.
- First `imem_req_valid` appears 1 cycle after `rst_n` deasserts (IDLE cycle).
- A response is never accepted in the same cycle as the request handshake. Earliest is the next cycle.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and `inst_ready` held high.
- `inst_valid` rises the cycle after the response edge. Once high it holds until the handshake; `inst`/`pc` are stable throughout.
- `halted`/`fault` assert on the edge that enters STOP.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - At the HOLD handshake, `dnpc[1:0]`≠0 sets `fault` and goes to STOP. `pc` still takes `dnpc`, for debug.
  - If `halt` is also set on that handshake, `fault` wins and `halted` stays 0.
- `IFU_ALIGN_CHECK_EN` undefined: `pc` <= {`dnpc[31:2]`, 2'b00} and no alignment fault is possible.

## Test plan
- Reset, zero-wait memory, `inst_ready`=1, `dnpc`=`pc`+4:
  - First request address is 32'h8000_0000.
  - Requests follow every 3 cycles at 8000_0004, 8000_0008, and so on.
  - `inst` matches memory words.
- Hold `imem_req_ready`=0 for 4 cycles, then 1 for a single cycle: `imem_addr` stays stable and exactly one request is accepted. Then delay the response 5 cycles: `inst_valid` stays 0 until the cycle after the response.
- `inst_ready`=0 for 3 cycles in HOLD with `dnpc`=32'h8000_0100: `inst`/`pc` are unchanged. After the handshake, the next request address is 8000_0100.
- `halt`=1 on a handshake: `halted`=1 next cycle and no further requests. A response pulse injected in STOP is ignored. `rst_n` pulse: `pc`=8000_0000, fetch restarts.
- `imem_rsp_err`=1: `fault`=1, `inst_valid` never asserts, no further requests. Separately, assert `rst_n`=0 while in WAIT: all outputs return to reset values asynchronously.
- `dnpc`=32'h8000_0102:
  - With `IFU_ALIGN_CHECK_EN`: `fault`=1.
  - Without it: the next request address is 8000_0100.
